// File: rtl/sample_packer.sv
// Packs SAMPLES ticked samples of sample_in into one wide word and
// offers it through a one-word valid/ready output register.
module sample_packer #(
  parameter int SAMPLE_W = 8,
  parameter int SAMPLES  = 8,
  parameter int DIV_W    = 16
) (
  input  logic                           fastclk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [DIV_W-1:0]               div_count,
  input  logic [SAMPLE_W-1:0]            sample_in,
  output logic [SAMPLE_W*SAMPLES-1:0]    out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overflow,
  output logic [$clog2(SAMPLES+1)-1:0]   fill_level
);

  localparam int WORD_W = SAMPLE_W * SAMPLES;
  localparam int FL_W   = $clog2(SAMPLES + 1);
  localparam logic [FL_W-1:0] LAST = FL_W'(SAMPLES - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [FL_W-1:0]   fill_q, fill_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;

  logic              tick;
  logic              done;
  logic              accept;
  logic              load;
  logic [WORD_W-1:0] word;

  always_comb begin
    tick   = enable && (div_q == div_count);
    done   = tick && (fill_q == LAST);
    accept = vld_q && out_ready;
    load   = done && (!vld_q || out_ready);

    // Counter only clears on a match, so a lowered divider wraps first.
    div_d = div_q + DIV_W'(1);
    if (!enable || tick) begin
      div_d = '0;
    end

    word = buf_q;
    word[(SAMPLES-1)*SAMPLE_W +: SAMPLE_W] = sample_in;

    buf_d  = buf_q;
    fill_d = fill_q;
    if (tick) begin
      for (int k = 0; k < SAMPLES; k++) begin
        if (fill_q == FL_W'(k)) begin
          buf_d[k*SAMPLE_W +: SAMPLE_W] = sample_in;
        end
      end
      fill_d = done ? '0 : fill_q + FL_W'(1);
    end

    out_d = load ? word : out_q;

    vld_d = vld_q;
    if (load) begin
      vld_d = 1'b1;
    end else if (accept) begin
      vld_d = 1'b0;
    end

    ovf_d = ovf_q | (done & vld_q & ~out_ready);
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      div_q  <= '0;
      fill_q <= '0;
      buf_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      fill_q <= fill_d;
      buf_q  <= buf_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = vld_q;
  assign overflow   = ovf_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer with a sample-queue reference model
// compared on every falling edge plus literal spot checks.
module tb_sample_packer;

  localparam int SW = 8;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int WW = SW * NS;

  logic          fastclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] div_count = '0;
  logic [SW-1:0] sample_in = '0;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out;
  logic          out_valid;
  logic          overflow;
  logic [2:0]    fill_level;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  sample_packer #(
    .SAMPLE_W(SW),
    .SAMPLES(NS),
    .DIV_W(DW)
  ) dut (
    .fastclk(fastclk),
    .reset(reset),
    .enable(enable),
    .div_count(div_count),
    .sample_in(sample_in),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .fill_level(fill_level)
  );

  always #10 fastclk = ~fastclk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collected samples and a one-word output slot
  logic [DW-1:0] m_cnt;
  logic [SW-1:0] m_s [NS];
  int            m_n;
  logic [WW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;
  logic          m_tk;
  logic [WW-1:0] m_w;

  always_comb begin
    m_tk = enable && (m_cnt == div_count);
    m_w = '0;
    for (int k = 0; k < NS - 1; k++) m_w[k*SW +: SW] = m_s[k];
    m_w[(NS-1)*SW +: SW] = sample_in;
  end

  always @(posedge fastclk) begin
    if (reset) begin
      m_cnt   <= '0;
      m_n     <= 0;
      m_out   <= '0;
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      m_cnt <= (enable && !m_tk) ? m_cnt + 16'd1 : '0;
      if (m_tk) begin
        if (m_n == NS - 1) begin
          m_n <= 0;
          if (!m_valid || out_ready) begin
            m_out   <= m_w;
            m_valid <= 1'b1;
          end else begin
            m_ovf <= 1'b1;
          end
        end else begin
          m_s[m_n] <= sample_in;
          m_n      <= m_n + 1;
        end
      end
      if (m_valid && out_ready && !(m_tk && m_n == NS - 1))
        m_valid <= 1'b0;
    end
  end

  always @(negedge fastclk) begin
    if (started) begin
      chk("model_out", out, m_out);
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      chk("model_fill", 32'(fill_level), 32'(m_n));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1);
    started = 1'b1;
    chk("rst_out", out, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_fill", 32'(fill_level), 32'h0);

    // 1: divider 3, one sample every 4 cycles
    reset = 1'b0;
    enable = 1'b1;
    div_count = 16'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_in = SW'(8'h11 * (i + 1));
      cyc(4);
      chk("t1_fill", 32'(fill_level), 32'((i + 1) % 4));
    end
    chk("t1_out", out, 32'h44332211);
    chk("t1_valid", 32'(out_valid), 32'h1);
    cyc(1);
    chk("t1_drop", 32'(out_valid), 32'h0);

    // 2: tick every cycle
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    div_count = 16'd0;
    for (int i = 0; i < 8; i++) begin
      sample_in = SW'(i);
      cyc(1);
      if (i == 3) chk("t2_w0", out, 32'h03020100);
      if (i == 7) chk("t2_w1", out, 32'h07060504);
    end
    chk("t2_ovf", 32'(overflow), 32'h0);

    // 3: consumer stalled across two completions
    enable = 1'b0;
    cyc(1);
    out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_in = SW'(8'h11 * (i + 1));
      cyc(1);
      if (i == 3) chk("t3_ovf_early", 32'(overflow), 32'h0);
    end
    chk("t3_out", out, 32'h44332211);
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_ovf", 32'(overflow), 32'h1);
    enable = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    chk("t3_drain", 32'(out_valid), 32'h0);
    chk("t3_sticky", 32'(overflow), 32'h1);

    // 4: ready arrives on the completing edge
    reset = 1'b1;
    cyc(1);
    chk("t4_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'hA0 + SW'(i);
      cyc(1);
    end
    chk("t4_wa", out, 32'hA3A2A1A0);
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'hB0 + SW'(i);
      if (i == 3) out_ready = 1'b1;
      cyc(1);
    end
    chk("t4_wb", out, 32'hB3B2B1B0);
    chk("t4_valid", 32'(out_valid), 32'h1);
    chk("t4_ovf", 32'(overflow), 32'h0);
    out_ready = 1'b0;
    enable = 1'b0;
    cyc(1);
    chk("t4_hold", out, 32'hB3B2B1B0);
    out_ready = 1'b1;
    cyc(1);
    chk("t4_drain", 32'(out_valid), 32'h0);

    // 5: pause after two samples
    div_count = 16'd2;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample_in = 8'hC0 + SW'(i);
      cyc(3);
    end
    chk("t5_fill_pre", 32'(fill_level), 32'h2);
    enable = 1'b0;
    sample_in = 8'hEE;
    cyc(20);
    chk("t5_fill_post", 32'(fill_level), 32'h2);
    enable = 1'b1;
    for (int i = 2; i < 4; i++) begin
      sample_in = 8'hC0 + SW'(i);
      cyc(3);
    end
    chk("t5_out", out, 32'hC3C2C1C0);

    // 6: reset with a partial word and a pending output
    out_ready = 1'b0;
    div_count = 16'd0;
    for (int i = 0; i < 3; i++) begin
      sample_in = 8'hD0 + SW'(i);
      cyc(1);
    end
    chk("t6_fill", 32'(fill_level), 32'h3);
    chk("t6_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    cyc(1);
    chk("t6_out", out, 32'h0);
    chk("t6_vld0", 32'(out_valid), 32'h0);
    chk("t6_fill0", 32'(fill_level), 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'hF0 + SW'(i);
      cyc(1);
    end
    chk("t6_word", out, 32'hF3F2F1F0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
